// File: rtl/dbg_cmd_bridge_pkg.sv
// Shared opcodes, response bytes and FSM encoding for the debug command bridge.
package dbg_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_MREAD = 8'h4D;

    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_DHI,
        GET_DLO,
        GET_CNT,
        BUS,
        SEND_HI,
        SEND_LO,
        SEND_STAT
    } state_t;

    function automatic logic is_get(state_t s);
        return s inside {GET_ADDR, GET_DHI, GET_DLO, GET_CNT};
    endfunction

endpackage

// File: rtl/dbg_cmd_bridge_if.sv
// UART byte streams and debug register bus seen by the command bridge.
interface dbg_cmd_bridge_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  dbg_a;
    logic [15:0] dbg_di;
    logic        dbg_we;
    logic        dbg_rd;
    logic [15:0] dbg_do;
    logic        dbg_ready;

    modport master (
        input  rx_data, rx_valid, tx_ready, dbg_do, dbg_ready,
        output tx_data, tx_valid, dbg_a, dbg_di, dbg_we, dbg_rd
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dbg_do, dbg_ready,
        input  tx_data, tx_valid, dbg_a, dbg_di, dbg_we, dbg_rd
    );

endinterface

// File: rtl/dbg_cmd_bridge_timer.sv
// Saturating cycle counter; o_expired marks the LIMIT-th consecutive enabled cycle.
module dbg_cmd_timer #(
    parameter int LIMIT = 1024,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/dbg_cmd_bridge.sv
// UART-byte-stream to debug-register-bus bridge: W/R/M frames, ACK/NAK replies.
module dbg_cmd_bridge
    import dbg_cmd_pkg::*;
#(
    parameter int RX_TIMEOUT  = 50000,
    parameter int BUS_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    dbg_cmd_bridge_if.master  bus,
    output logic              busy,
    output logic              overrun
);

    state_t      r_state;
    logic [7:0]  r_op;
    logic [7:0]  r_cnt;
    logic [7:0]  r_a;
    logic [15:0] r_di;
    logic [7:0]  r_lo;
    logic [7:0]  r_tx;
    logic        r_txv;
    logic        r_we;
    logic        r_rd;
    logic        r_ovr;

    logic w_in_get;
    logic w_in_bus;
    logic w_rx_exp;
    logic w_bus_exp;

    assign w_in_get = is_get(r_state);
    assign w_in_bus = (r_state == BUS);

    // A received byte restarts the inter-byte window, so it always beats expiry.
    dbg_cmd_timer #(.LIMIT(RX_TIMEOUT), .WIDTH(16)) u_rx_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (!w_in_get || bus.rx_valid),
        .i_en      (w_in_get && !bus.rx_valid),
        .o_expired (w_rx_exp)
    );

    dbg_cmd_timer #(.LIMIT(BUS_TIMEOUT)) u_bus_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (!w_in_bus),
        .i_en      (w_in_bus),
        .o_expired (w_bus_exp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_di    <= '0;
            r_lo    <= '0;
            r_tx    <= '0;
            r_txv   <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (bus.rx_valid && !w_in_get && r_state != IDLE) begin
                r_ovr <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        r_op  <= bus.rx_data;
                        r_cnt <= '0;
                        if (bus.rx_data inside {OP_WRITE, OP_READ, OP_MREAD}) begin
                            r_state <= GET_ADDR;
                        end else begin
                            r_tx    <= RSP_NAK;
                            r_txv   <= 1'b1;
                            r_state <= SEND_STAT;
                        end
                    end
                end
                GET_ADDR: begin
                    if (bus.rx_valid) begin
                        r_a <= bus.rx_data;
                        unique case (1'b1)
                            (r_op == OP_WRITE): r_state <= GET_DHI;
                            (r_op == OP_MREAD): r_state <= GET_CNT;
                            default: begin
                                r_rd    <= 1'b1;
                                r_state <= BUS;
                            end
                        endcase
                    end else if (w_rx_exp) begin
                        r_state <= IDLE;
                    end
                end
                GET_DHI: begin
                    if (bus.rx_valid) begin
                        r_di[15:8] <= bus.rx_data;
                        r_state    <= GET_DLO;
                    end else if (w_rx_exp) begin
                        r_state <= IDLE;
                    end
                end
                GET_DLO: begin
                    if (bus.rx_valid) begin
                        r_di[7:0] <= bus.rx_data;
                        r_we      <= 1'b1;
                        r_state   <= BUS;
                    end else if (w_rx_exp) begin
                        r_state <= IDLE;
                    end
                end
                GET_CNT: begin
                    if (bus.rx_valid) begin
                        r_cnt   <= bus.rx_data;
                        r_rd    <= 1'b1;
                        r_state <= BUS;
                    end else if (w_rx_exp) begin
                        r_state <= IDLE;
                    end
                end
                BUS: begin
                    // Ready in the expiry cycle still completes the access.
                    if (bus.dbg_ready) begin
                        r_we  <= 1'b0;
                        r_rd  <= 1'b0;
                        r_txv <= 1'b1;
                        if (r_we) begin
                            r_tx    <= RSP_ACK;
                            r_state <= SEND_STAT;
                        end else begin
                            r_tx    <= bus.dbg_do[15:8];
                            r_lo    <= bus.dbg_do[7:0];
                            r_state <= SEND_HI;
                        end
                    end else if (w_bus_exp) begin
                        r_we    <= 1'b0;
                        r_rd    <= 1'b0;
                        r_cnt   <= '0;
                        r_tx    <= RSP_NAK;
                        r_txv   <= 1'b1;
                        r_state <= SEND_STAT;
                    end
                end
                SEND_HI: begin
                    if (bus.tx_ready) begin
                        r_tx    <= r_lo;
                        r_state <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (bus.tx_ready) begin
                        r_txv <= 1'b0;
                        if (r_cnt != 8'd0) begin
                            r_cnt   <= r_cnt - 8'd1;
                            r_rd    <= 1'b1;
                            r_state <= BUS;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                SEND_STAT: begin
                    if (bus.tx_ready) begin
                        r_txv   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tx_data = r_tx;
    assign bus.tx_valid = r_txv;
    assign bus.dbg_a   = r_a;
    assign bus.dbg_di  = r_di;
    assign bus.dbg_we  = r_we;
    assign bus.dbg_rd  = r_rd;
    assign busy        = (r_state != IDLE);
    assign overrun     = r_ovr;

endmodule
